y86_fetch_unit: RTL and testbench

Parametrised fetch stage for the Y86 pipeline. It replaces the bare PC register and IF/ID latch with a PC generator, a combinational instruction-length/field decoder and a QDEPTH-entry decoded-instruction queue. It presents one decoded instruction per cycle to decode through a valid/ready handshake. It supports redirects (branch/return resolution) and stops fetching on `halt` or an invalid icode.

---
 rtl/y86_pkg.sv | 42 ++++
 rtl/y86_fetch_queue.sv | 53 +++++
 rtl/y86_fetch_unit.sv | 114 +++++++++++
 tb/tb_y86_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86 opcode constants plus the length and legality rules shared by the fetch path.
// Pure definitions: no state, no latency.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] valc;
        logic        err;
    } dec_t;

    function automatic logic icode_valid(input logic [3:0] icode);
        return icode <= I_POPL;
    endfunction

    // Illegal icodes are treated as one byte so fetch can still report them.
    function automatic logic [2:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_RRMOVL, I_OPL, I_PUSHL, I_POPL: return 3'd2;
            I_IRMOVL, I_RMMOVL, I_MRMOVL:     return 3'd6;
            I_JXX, I_CALL:                    return 3'd5;
            default:                          return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/y86_fetch_queue.sv
// Circular FIFO of decoded fetch entries; data visible at head the cycle after push.
// Caller must not push when full without a same-cycle pop; flush empties it in one cycle.
module y86_fetch_queue #(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 8,
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int CNT_W = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86 fetch: PC generator, combinational length/field decode, QDEPTH-deep decoded queue.
// One instruction per cycle, head valid one cycle after fetch; fetch stalls when the queue is full.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              QDEPTH   = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] rom_addr_o,
    input  logic [47:0]     rom_data_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [PC_W-1:0] id_pc_o,
    output logic [3:0]      id_icode_o,
    output logic [3:0]      id_ifun_o,
    output logic [3:0]      id_rA_o,
    output logic [3:0]      id_rB_o,
    output logic [31:0]     id_valC_o,
    output logic [PC_W-1:0] id_valP_o,
    output logic            id_err_o,
    output logic            halted_o
);

    localparam int CNT_W   = $clog2(QDEPTH + 1);
    localparam int ENTRY_W = 2 * PC_W + $bits(dec_t);

    logic [PC_W-1:0]    fetch_pc;
    logic               halted;
    logic [3:0]         icode;
    logic [2:0]         len;
    logic [PC_W-1:0]    valp;
    dec_t               dec;
    dec_t               head_dec;
    logic [CNT_W-1:0]   count;
    logic               pop;
    logic               push;
    logic               stop;
    logic [ENTRY_W-1:0] head_data;

    assign icode = rom_data_i[47:44];
    assign len   = instr_len(icode);
    assign valp  = fetch_pc + PC_W'(len);

    always_comb begin
        dec       = '0;
        dec.icode = icode;
        dec.ifun  = rom_data_i[43:40];
        dec.ra    = RNONE;
        dec.rb    = RNONE;
        dec.err   = !icode_valid(icode);
        if (len == 3'd2 || len == 3'd6) begin
            dec.ra = rom_data_i[39:36];
            dec.rb = rom_data_i[35:32];
        end
        // Constant word is stored little-endian in the byte stream.
        case (icode)
            I_IRMOVL, I_RMMOVL, I_MRMOVL:
                dec.valc = {rom_data_i[7:0], rom_data_i[15:8], rom_data_i[23:16], rom_data_i[31:24]};
            I_JXX, I_CALL:
                dec.valc = {rom_data_i[15:8], rom_data_i[23:16], rom_data_i[31:24], rom_data_i[39:32]};
            default: ;
        endcase
    end

    assign id_valid_o = (count != '0);
    assign pop        = id_valid_o && id_ready_i && !redirect_i;
    assign push       = !redirect_i && !halted && ((count < CNT_W'(QDEPTH)) || pop);
    assign stop       = (icode == I_HALT) || !icode_valid(icode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            halted   <= 1'b0;
        end else if (push) begin
            fetch_pc <= valp;
            if (stop) begin
                halted <= 1'b1;
            end
        end
    end

    y86_fetch_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (push),
        .push_data ({fetch_pc, valp, dec}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign {id_pc_o, id_valP_o, head_dec} = head_data;
    assign id_icode_o = head_dec.icode;
    assign id_ifun_o  = head_dec.ifun;
    assign id_rA_o    = head_dec.ra;
    assign id_rB_o    = head_dec.rb;
    assign id_valC_o  = head_dec.valc;
    assign id_err_o   = head_dec.err;
    assign rom_addr_o = fetch_pc;
    assign halted_o   = halted;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Bench for y86_fetch_unit: directed scenarios plus random ready/redirect traffic,
// every accepted instruction compared with a byte-level decode of the ROM image.
module tb_y86_fetch_unit;

    localparam int LEN_TAB [16] = '{1, 1, 2, 6, 6, 6, 2, 5, 5, 1, 2, 2, 1, 1, 1, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [47:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [3:0]  id_icode, id_ifun, id_rA, id_rB;
    logic [31:0] id_valC;
    logic [31:0] id_valP;
    logic        id_err;
    logic        halted;

    logic [7:0]  w8_addr;
    logic [47:0] w8_data = 48'h80_11_22_33_44_00;
    logic        w8_redirect = 1'b0;
    logic [7:0]  w8_redirect_pc = 8'h00;
    logic        w8_ready = 1'b1;
    logic        w8_valid;
    logic [7:0]  w8_pc, w8_valP;
    logic [3:0]  w8_icode, w8_ifun, w8_rA, w8_rB;
    logic [31:0] w8_valC;
    logic        w8_err, w8_halted;

    logic [7:0]  rom [0:255];

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] valc;
        logic [31:0] valp;
        logic        err;
    } mdl_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    bit          mdl_done;

    always #5 clk = ~clk;

    always_comb begin
        rom_data = '0;
        for (int k = 0; k < 6; k++) begin
            rom_data[47 - 8 * k -: 8] = rom[8'(rom_addr[7:0] + 8'(k))];
        end
    end

    y86_fetch_unit dut (
        .clk(clk), .rst(rst), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .id_valid_o(id_valid), .id_ready_i(id_ready), .id_pc_o(id_pc),
        .id_icode_o(id_icode), .id_ifun_o(id_ifun), .id_rA_o(id_rA), .id_rB_o(id_rB),
        .id_valC_o(id_valC), .id_valP_o(id_valP), .id_err_o(id_err), .halted_o(halted)
    );

    y86_fetch_unit #(.PC_W(8), .QDEPTH(2), .RESET_PC(8'hFD)) dut_w8 (
        .clk(clk), .rst(rst), .rom_addr_o(w8_addr), .rom_data_i(w8_data),
        .redirect_i(w8_redirect), .redirect_pc_i(w8_redirect_pc),
        .id_valid_o(w8_valid), .id_ready_i(w8_ready), .id_pc_o(w8_pc),
        .id_icode_o(w8_icode), .id_ifun_o(w8_ifun), .id_rA_o(w8_rA), .id_rB_o(w8_rB),
        .id_valC_o(w8_valC), .id_valP_o(w8_valP), .id_err_o(w8_err), .halted_o(w8_halted)
    );

    // Reference decode straight from the ROM bytes at an arbitrary pc.
    function automatic mdl_t model_dec(input logic [31:0] pc);
        mdl_t       m;
        logic [7:0] b [6];
        int         len;
        for (int k = 0; k < 6; k++) begin
            b[k] = rom[8'(pc[7:0] + 8'(k))];
        end
        m.icode = b[0][7:4];
        m.ifun  = b[0][3:0];
        m.err   = (int'(m.icode) > 11);
        len     = LEN_TAB[m.icode];
        m.ra    = 4'hF;
        m.rb    = 4'hF;
        if (len == 2 || len == 6) begin
            m.ra = b[1][7:4];
            m.rb = b[1][3:0];
        end
        m.valc = 32'd0;
        if (len >= 5) begin
            for (int k = 0; k < 4; k++) begin
                m.valc = m.valc | (32'(b[len - 4 + k]) << (8 * k));
            end
        end
        m.valp = pc + 32'(len);
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: apply inputs, score an accept, advance to the next negedge.
    task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
        mdl_t m;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (mdl_done) check("post_halt_idle", id_valid, 0);
        if (id_valid && rdy && !redir) begin
            m = model_dec(exp_pc);
            check("pc", id_pc, exp_pc);
            check("icode", id_icode, m.icode);
            check("ifun", id_ifun, m.ifun);
            check("rA", id_rA, m.ra);
            check("rB", id_rB, m.rb);
            check("valC", id_valC, m.valc);
            check("valP", id_valP, m.valp);
            check("err", id_err, m.err);
            last_pc = exp_pc;
            exp_pc  = m.valp;
            n_deliv++;
            if (m.icode == 4'h0 || m.err) mdl_done = 1'b1;
        end
        if (redir) begin
            exp_pc   = rpc;
            mdl_done = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_until_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !mdl_done; i++) begin
            drive(1'b1, 1'b0, 32'd0);
        end
        check(tag, mdl_done, 1);
    endtask

    initial begin
        logic [31:0] a_pc  [3] = '{32'h0, 32'h1, 32'h3};
        logic [3:0]  a_ic  [3] = '{4'h1, 4'h2, 4'h3};
        logic [3:0]  a_ra  [3] = '{4'hF, 4'h1, 4'hF};
        logic [3:0]  a_rb  [3] = '{4'hF, 4'h2, 4'h4};
        logic [31:0] a_vc  [3] = '{32'h0, 32'h0, 32'h12345678};
        logic [31:0] a_vp  [3] = '{32'h1, 32'h3, 32'h9};
        logic [7:0]  prog0 [9] = '{8'h10, 8'h20, 8'h12, 8'h30, 8'hF4, 8'h78, 8'h56, 8'h34, 8'h12};
        logic [31:0] stall_addr;
        logic        rdy, redir;
        logic [31:0] rpc;
        int          a, ic, base_deliv;

        for (int i = 0; i < 256; i++) rom[i] = 8'h10;
        for (int i = 0; i < 9; i++) rom[i] = prog0[i];
        rom[8'h10] = 8'h00;
        rom[8'h20] = 8'hE0;
        a = 'h40;
        while (a < 'hE8) begin
            ic = $urandom_range(1, 11);
            rom[a] = {ic[3:0], 4'($urandom_range(0, 15))};
            for (int k = 1; k < LEN_TAB[ic]; k++) rom[a + k] = 8'($urandom);
            a += LEN_TAB[ic];
        end
        rom[a] = 8'h00;

        rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mdl_done = 1'b0; exp_pc = '0; last_pc = '0;
        @(negedge clk); @(negedge clk);
        check("rst_valid", id_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_icode", id_icode, 0);
        check("rst_valC", id_valC, 0);
        check("rst_valP", id_valP, 0);
        check("rst_err", id_err, 0);
        check("rst_w8_addr", w8_addr, 8'hFD);
        check("rst_w8_valid", w8_valid, 0);

        // Straight-line program from address 0, decode always ready.
        rst = 1'b0;
        check("pre_first_edge_valid", id_valid, 0);
        drive(1'b1, 1'b0, 32'd0);
        check("w8_valid", w8_valid, 1);
        check("w8_pc", w8_pc, 8'hFD);
        check("w8_icode", w8_icode, 4'h8);
        check("w8_valC", w8_valC, 32'h44332211);
        check("w8_valP_wrap", w8_valP, 8'h02);
        for (int i = 0; i < 3; i++) begin
            check("seq_valid", id_valid, 1);
            check("seq_pc", id_pc, a_pc[i]);
            check("seq_icode", id_icode, a_ic[i]);
            check("seq_rA", id_rA, a_ra[i]);
            check("seq_rB", id_rB, a_rb[i]);
            check("seq_valC", id_valC, a_vc[i]);
            check("seq_valP", id_valP, a_vp[i]);
            drive(1'b1, 1'b0, 32'd0);
        end

        // Backpressure: queue fills to two entries and the fetch address freezes.
        stall_addr = model_dec(model_dec(exp_pc).valp).valp;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            check("stall_valid", id_valid, 1);
            check("stall_head_pc", id_pc, exp_pc);
            check("stall_rom_addr", rom_addr, stall_addr);
        end

        // Release and run into the halt at 0x10.
        run_until_done("halt_reached", 40);
        check("halt_pc", last_pc, 32'h10);
        for (int i = 0; i < 3; i++) begin
            check("halted", halted, 1);
            check("halt_rom_addr", rom_addr, 32'h11);
            drive(1'b1, 1'b0, 32'd0);
        end

        // Redirect to 0 restarts fetch.
        drive(1'b1, 1'b1, 32'd0);
        check("redir0_empty", id_valid, 0);
        check("redir0_unhalt", halted, 0);
        drive(1'b1, 1'b0, 32'd0);
        check("redir0_valid", id_valid, 1);
        check("redir0_pc", id_pc, 32'h0);
        drive(1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0);

        // Redirect to 0x40 while full, coinciding with a ready head.
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        check("full_before_redir", id_valid, 1);
        drive(1'b1, 1'b1, 32'h40);
        check("redir40_empty", id_valid, 0);
        drive(1'b0, 1'b0, 32'd0);
        check("redir40_valid", id_valid, 1);
        check("redir40_pc", id_pc, 32'h40);

        // Illegal icode at 0x20.
        drive(1'b1, 1'b1, 32'h20);
        check("redir20_empty", id_valid, 0);
        drive(1'b1, 1'b0, 32'd0);
        check("bad_valid", id_valid, 1);
        check("bad_err", id_err, 1);
        check("bad_icode", id_icode, 4'hE);
        check("bad_valP", id_valP, 32'h21);
        drive(1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        check("bad_halted", halted, 1);
        check("bad_rom_addr", rom_addr, 32'h21);

        // Random ready and redirects over the generated program.
        drive(1'b1, 1'b1, 32'h40);
        base_deliv = n_deliv;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if (mdl_done) begin
                redir = 1'b1;
                rpc   = 32'h40;
            end else begin
                redir = ($urandom_range(0, 24) == 0);
                rpc   = 32'h40 + 32'($urandom_range(0, 'h60));
            end
            drive(rdy, redir, rpc);
        end
        check("rand_progress", (n_deliv - base_deliv) >= 50, 1);

        // Asynchronous reset with a full queue.
        drive(1'b1, 1'b1, 32'h40);
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        check("pre_rst_valid", id_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", id_valid, 0);
        check("arst_halted", halted, 0);
        check("arst_rom_addr", rom_addr, 0);
        check("arst_id_pc", id_pc, 0);
        check("arst_valP", id_valP, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
